// File: rtl/fmlbrg_wb_arbiter.sv
// Two-master Wishbone arbiter in front of the FML bridge slave port, with a per-grant ack quota.
// Optional build macro FMLARB_FIXED_PRIO_EN: m0 wins ties and is never preempted; the quota applies to m1 only.
module fmlbrg_wb_arbiter #(
  parameter int fml_depth = 23,
  parameter int max_burst = 8
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,

  input  logic [fml_depth-2:0] m0_adr_i,
  input  logic [15:0]          m0_dat_i,
  output logic [15:0]          m0_dat_o,
  input  logic [1:0]           m0_sel_i,
  input  logic                 m0_cyc_i,
  input  logic                 m0_stb_i,
  input  logic                 m0_tga_i,
  input  logic                 m0_we_i,
  output logic                 m0_ack_o,

  input  logic [fml_depth-2:0] m1_adr_i,
  input  logic [15:0]          m1_dat_i,
  output logic [15:0]          m1_dat_o,
  input  logic [1:0]           m1_sel_i,
  input  logic                 m1_cyc_i,
  input  logic                 m1_stb_i,
  input  logic                 m1_tga_i,
  input  logic                 m1_we_i,
  output logic                 m1_ack_o,

  output logic [fml_depth-2:0] s_adr_o,
  output logic [15:0]          s_dat_o,
  input  logic [15:0]          s_dat_i,
  output logic [1:0]           s_sel_o,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  output logic                 s_tga_o,
  output logic                 s_we_o,
  input  logic                 s_ack_i,

  output logic [1:0]           gnt_o
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  localparam logic [8:0] MAX_B = 9'(max_burst);

  state_t     state_q, state_d;
  logic       last_q, last_d;    // 1 = m1 was granted most recently
  logic [7:0] count_q, count_d;

  logic       req0, req1;
  logic       g0, g1;
  logic [8:0] count_inc;
  logic       quota_hit;
  logic [7:0] count_sat;
  logic       preempt0, preempt1;
  logic       tie_to_m0;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  // ">=" rather than "==" so a count that saturated while uncontested still yields on the next ack.
  assign count_inc = {1'b0, count_q} + 9'd1;
  assign quota_hit = (count_inc >= MAX_B);
  assign count_sat = quota_hit ? MAX_B[7:0] : count_inc[7:0];

`ifdef FMLARB_FIXED_PRIO_EN
  assign tie_to_m0 = 1'b1;
  assign preempt0  = 1'b0;
`else
  assign tie_to_m0 = last_q;
  assign preempt0  = quota_hit & req1;
`endif
  assign preempt1 = quota_hit & req0;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        count_d = 8'd0;
        if (req0 && (!req1 || tie_to_m0)) begin
          state_d = GNT0;
          last_d  = 1'b0;
        end else if (req1) begin
          state_d = GNT1;
          last_d  = 1'b1;
        end
      end
      GNT0: begin
        if (s_ack_i) begin
          if (preempt0) begin
            state_d = GNT1;
            last_d  = 1'b1;
            count_d = 8'd0;
          end else begin
            count_d = count_sat;
          end
        end else if (!m0_cyc_i) begin
          state_d = IDLE;
          count_d = 8'd0;
        end
      end
      GNT1: begin
        if (s_ack_i) begin
          if (preempt1) begin
            state_d = GNT0;
            last_d  = 1'b0;
            count_d = 8'd0;
          end else begin
            count_d = count_sat;
          end
        end else if (!m1_cyc_i) begin
          state_d = IDLE;
          count_d = 8'd0;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = 8'd0;
      end
    endcase
  end

  assign g0    = (state_q == GNT0);
  assign g1    = (state_q == GNT1);
  assign gnt_o = {g1, g0};

  // STB is qualified with CYC so a dropped cycle never leaves a strobe in flight.
  assign s_adr_o = g1 ? m1_adr_i : m0_adr_i;
  assign s_dat_o = g1 ? m1_dat_i : m0_dat_i;
  assign s_sel_o = g1 ? m1_sel_i : m0_sel_i;
  assign s_cyc_o = (g0 & m0_cyc_i) | (g1 & m1_cyc_i);
  assign s_stb_o = (g0 & m0_cyc_i & m0_stb_i) | (g1 & m1_cyc_i & m1_stb_i);
  assign s_we_o  = (g0 & m0_we_i) | (g1 & m1_we_i);
  assign s_tga_o = (g0 & m0_tga_i) | (g1 & m1_tga_i);

  assign m0_ack_o = s_ack_i & g0;
  assign m1_ack_o = s_ack_i & g1;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_fmlbrg_wb_arbiter.sv
// Directed bench for fmlbrg_wb_arbiter: two modelled masters and a one-wait-state slave.
module tb_fmlbrg_wb_arbiter;

  localparam int AW = 22;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic [AW-1:0] m0_adr_i = '0, m1_adr_i = '0;
  logic [15:0]   m0_dat_i = '0, m1_dat_i = '0;
  logic [15:0]   m0_dat_o, m1_dat_o;
  logic [1:0]    m0_sel_i = '0, m1_sel_i = '0;
  logic          m0_cyc_i = 0, m0_stb_i = 0, m0_tga_i = 0, m0_we_i = 0, m0_ack_o;
  logic          m1_cyc_i = 0, m1_stb_i = 0, m1_tga_i = 0, m1_we_i = 0, m1_ack_o;
  logic [AW-1:0] s_adr_o;
  logic [15:0]   s_dat_o, s_dat_i;
  logic [1:0]    s_sel_o, gnt_o;
  logic          s_cyc_o, s_stb_o, s_tga_o, s_we_o;
  logic          s_ack_i = 1'b0;

  int checks = 0;
  int errors = 0;

  fmlbrg_wb_arbiter #(.fml_depth(23), .max_burst(8)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_sel_i(m0_sel_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_tga_i(m0_tga_i), .m0_we_i(m0_we_i), .m0_ack_o(m0_ack_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_sel_i(m1_sel_i),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_tga_i(m1_tga_i), .m1_we_i(m1_we_i), .m1_ack_o(m1_ack_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_sel_o(s_sel_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_tga_o(s_tga_o), .s_we_o(s_we_o), .s_ack_i(s_ack_i),
    .gnt_o(gnt_o)
  );

  always #5 sys_clk = ~sys_clk;

  // Slave: acks every strobe one cycle after it appears, read data derived from address.
  always @(posedge sys_clk) begin
    if (sys_rst) s_ack_i <= 1'b0;
    else         s_ack_i <= s_stb_o & ~s_ack_i;
  end
  assign s_dat_i = s_adr_o[15:0] ^ 16'hA5A5;

  typedef struct {
    logic [1:0]    gnt;
    logic          stb;
    logic          ack0;
    logic          ack1;
    logic          tga;
    logic          we;
    logic [1:0]    sel;
    logic [15:0]   wdat;
    logic [15:0]   rdat;
    logic [AW-1:0] adr;
    logic          r0;
    logic          r1;
  } rec_t;

  rec_t          log_q[$];
  int            seq_q[$];
  int            exp_q[$];
  logic [AW-1:0] base0, base1;
  logic          we0, we1, tga0, tga1;
  logic [15:0]   wd0, wd1;
  logic [1:0]    sel0, sel1;

  task automatic do_reset();
    sys_rst  = 1'b1;
    m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    repeat (2) @(posedge sys_clk);
    #1;
  endtask

  task automatic set_defaults();
    base0 = 22'h000100; base1 = 22'h000200;
    we0 = 0; we1 = 0; tga0 = 0; tga1 = 0;
    wd0 = 16'h0000; wd1 = 16'h0000; sel0 = 2'b11; sel1 = 2'b11;
  endtask

  // Two masters doing n0/n1 back-to-back transfers; m1 starts d1 cycles late. Logs every cycle.
  task automatic run_masters(input int n0, input int n1, input int d1, input int budget, output bit done);
    int a0, a1, cyc;
    bit r0, r1;
    a0 = 0; a1 = 0; cyc = 0; done = 0;
    log_q.delete(); seq_q.delete();
    r0 = (n0 > 0); r1 = (n1 > 0) && (d1 == 0);
    m0_adr_i = base0; m0_we_i = we0; m0_dat_i = wd0; m0_sel_i = sel0; m0_tga_i = tga0;
    m1_adr_i = base1; m1_we_i = we1; m1_dat_i = wd1; m1_sel_i = sel1; m1_tga_i = tga1;
    m0_cyc_i = r0; m0_stb_i = r0; m1_cyc_i = r1; m1_stb_i = r1;
    while (cyc < budget) begin
      rec_t rc;
      @(posedge sys_clk); #1;
      cyc++;
      rc.gnt = gnt_o; rc.stb = s_stb_o; rc.ack0 = m0_ack_o; rc.ack1 = m1_ack_o;
      rc.tga = s_tga_o; rc.we = s_we_o; rc.sel = s_sel_o; rc.wdat = s_dat_o;
      rc.rdat = m0_dat_o; rc.adr = s_adr_o; rc.r0 = r0; rc.r1 = r1;
      log_q.push_back(rc);
      if (m0_ack_o) begin
        a0++; seq_q.push_back(0);
        if (a0 == n0) begin r0 = 0; m0_cyc_i = 0; m0_stb_i = 0; end
        else m0_adr_i = base0 + 22'(a0);
      end
      if (m1_ack_o) begin
        a1++; seq_q.push_back(1);
        if (a1 == n1) begin r1 = 0; m1_cyc_i = 0; m1_stb_i = 0; end
        else m1_adr_i = base1 + 22'(a1);
      end
      if (d1 > 0 && cyc == d1 && n1 > 0) begin
        r1 = 1; m1_cyc_i = 1; m1_stb_i = 1;
      end
      if (a0 == n0 && a1 == n1) begin done = 1; break; end
    end
    m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
  endtask

  task automatic add_exp(input int who, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(who);
  endtask

  function automatic int first_diff();
    if (seq_q.size() != exp_q.size()) return (seq_q.size() < exp_q.size()) ? seq_q.size() : exp_q.size();
    for (int i = 0; i < seq_q.size(); i++) if (seq_q[i] != exp_q[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    do_reset();
    checks++;
    if ({gnt_o, s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b cyc=%b stb=%b ack0=%b ack1=%b, want all 0",
               gnt_o, s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o);
    end
    sys_rst = 1'b0;
  endtask

  task automatic test_single_read();
    bit done;
    do_reset(); sys_rst = 0; set_defaults();
    base0 = 22'h000010;
    run_masters(1, 0, 0, 20, done);
    checks++;
    if (!done || log_q.size() < 2) begin
      errors++; $display("FAIL single_read_timeout: done=%0d cycles=%0d want done=1", done, log_q.size());
    end else begin
      checks++;
      if (log_q[0].gnt !== 2'b01 || log_q[0].stb !== 1'b1 || log_q[0].adr !== 22'h000010) begin
        errors++;
        $display("FAIL single_read_grant: gnt=%b stb=%b adr=%h want 01 1 000010",
                 log_q[0].gnt, log_q[0].stb, log_q[0].adr);
      end
      checks++;
      if (log_q[1].ack0 !== 1'b1 || log_q[1].ack1 !== 1'b0 || log_q[1].rdat !== 16'hA5B5) begin
        errors++;
        $display("FAIL single_read_ack: ack0=%b ack1=%b rdat=%h want 1 0 a5b5",
                 log_q[1].ack0, log_q[1].ack1, log_q[1].rdat);
      end
    end
  endtask

  task automatic test_tie();
    bit done; int d;
    do_reset(); sys_rst = 0; set_defaults();
    run_masters(1, 1, 0, 40, done);
    exp_q.delete(); add_exp(0, 1); add_exp(1, 1);
    d = first_diff();
    checks++;
    if (!done || d != -1 || log_q[0].gnt !== 2'b01) begin
      errors++;
      $display("FAIL tie_order: done=%0d diff_at=%0d first_gnt=%b want done=1 diff=-1 gnt=01",
               done, d, log_q[0].gnt);
    end
  endtask

  task automatic test_quota();
    bit done; int d, gap, max_gap, both;
    do_reset(); sys_rst = 0; set_defaults();
    run_masters(20, 10, 0, 300, done);
    exp_q.delete();
`ifdef FMLARB_FIXED_PRIO_EN
    add_exp(0, 20); add_exp(1, 10);
`else
    add_exp(0, 8); add_exp(1, 8); add_exp(0, 8); add_exp(1, 2); add_exp(0, 4);
`endif
    d = first_diff();
    checks++;
    if (!done || d != -1) begin
      errors++; $display("FAIL quota_sequence: done=%0d diff_at=%0d len=%0d want done=1 diff=-1 len=30",
                         done, d, seq_q.size());
    end
    gap = 0; max_gap = 0; both = 0;
    foreach (log_q[i]) begin
      if (log_q[i].ack0 && log_q[i].ack1) both++;
      if (log_q[i].r0 && log_q[i].r1 && !log_q[i].stb) gap++; else gap = 0;
      if (gap > max_gap) max_gap = gap;
    end
    checks++;
    if (both != 0) begin errors++; $display("FAIL quota_double_ack: cycles=%0d want 0", both); end
    checks++;
    if (max_gap > 1) begin errors++; $display("FAIL quota_stb_gap: gap=%0d want <=1", max_gap); end
  endtask

  task automatic test_switch_edge();
    bit done; int n, idx;
    logic [1:0] eg; logic [AW-1:0] ea;
    do_reset(); sys_rst = 0; set_defaults();
    run_masters(9, 1, 0, 100, done);
    n = 0; idx = -1;
    foreach (log_q[i]) if (log_q[i].ack0) begin n++; if (n == 8 && idx < 0) idx = i; end
`ifdef FMLARB_FIXED_PRIO_EN
    eg = 2'b01; ea = 22'h000108;
`else
    eg = 2'b10; ea = 22'h000200;
`endif
    checks++;
    if (idx < 0 || idx + 1 >= log_q.size()) begin
      errors++; $display("FAIL switch_eighth_ack: idx=%0d want found", idx);
    end else begin
      checks++;
      if (log_q[idx+1].gnt !== eg || log_q[idx+1].stb !== 1'b1 || log_q[idx+1].adr !== ea ||
          log_q[idx+1].ack0 !== 1'b0 || log_q[idx+1].ack1 !== 1'b0) begin
        errors++;
        $display("FAIL switch_next_cycle: gnt=%b stb=%b adr=%h acks=%b%b want gnt=%b stb=1 adr=%h acks=00",
                 log_q[idx+1].gnt, log_q[idx+1].stb, log_q[idx+1].adr,
                 log_q[idx+1].ack0, log_q[idx+1].ack1, eg, ea);
      end
    end
  endtask

  task automatic test_tga_write();
    bit done, seen; int d, bad, wr_ok;
    do_reset(); sys_rst = 0; set_defaults();
    we0 = 1; wd0 = 16'hBEEF; sel0 = 2'b11; tga1 = 1; sel1 = 2'b01;
    run_masters(1, 1, 0, 40, done);
    exp_q.delete(); add_exp(0, 1); add_exp(1, 1);
    d = first_diff();
    bad = 0; seen = 0; wr_ok = 0;
    foreach (log_q[i]) begin
      if (log_q[i].tga && log_q[i].gnt != 2'b10) bad++;
      if (log_q[i].tga && log_q[i].gnt == 2'b10) seen = 1;
      if (log_q[i].ack0 && log_q[i].we && log_q[i].wdat == 16'hBEEF && log_q[i].sel == 2'b11) wr_ok++;
    end
    checks++;
    if (!done || d != -1) begin
      errors++; $display("FAIL tga_acks_once: done=%0d diff_at=%0d len=%0d want 1 -1 2", done, d, seq_q.size());
    end
    checks++;
    if (bad != 0 || !seen) begin
      errors++; $display("FAIL tga_only_m1: stray=%0d seen=%0d want 0 1", bad, seen);
    end
    checks++;
    if (wr_ok != 1) begin errors++; $display("FAIL m0_write_beef: got=%0d want 1", wr_ok); end
  endtask

  task automatic test_reset_mid();
    do_reset(); sys_rst = 0; set_defaults();
    m0_adr_i = 22'h000040; m0_we_i = 0; m0_cyc_i = 1; m0_stb_i = 1;
    @(posedge sys_clk); #1;
    checks++;
    if (gnt_o !== 2'b01 || s_stb_o !== 1'b1) begin
      errors++; $display("FAIL reset_mid_pre: gnt=%b stb=%b want 01 1", gnt_o, s_stb_o);
    end
    sys_rst = 1;
    @(posedge sys_clk); #1;
    checks++;
    if (gnt_o !== 2'b00 || m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0 || s_stb_o !== 1'b0) begin
      errors++; $display("FAIL reset_mid_post: gnt=%b ack0=%b ack1=%b stb=%b want 00 0 0 0",
                         gnt_o, m0_ack_o, m1_ack_o, s_stb_o);
    end
    m0_cyc_i = 0; m0_stb_i = 0; sys_rst = 0;
  endtask

  task automatic test_saturated_quota();
    bit done; int d;
    do_reset(); sys_rst = 0; set_defaults();
    run_masters(20, 10, 21, 300, done);
    exp_q.delete();
`ifdef FMLARB_FIXED_PRIO_EN
    add_exp(0, 20); add_exp(1, 10);
`else
    add_exp(0, 11); add_exp(1, 8); add_exp(0, 8); add_exp(1, 2); add_exp(0, 1);
`endif
    d = first_diff();
    checks++;
    if (!done || d != -1) begin
      errors++; $display("FAIL saturated_quota: done=%0d diff_at=%0d len=%0d want 1 -1 30", done, d, seq_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_quota();
    test_switch_edge();
    test_tga_write();
    test_reset_mid();
    test_saturated_quota();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
